// File: rtl/regfile_dump_unit_if.sv
// Register-file read port plus byte-stream port of the register dump unit.
// Stream handshake: a byte transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_data must hold steady.
interface regfile_dump_unit_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_unit.sv
// Walks every register-file entry once, snapshotting it in a FETCH cycle and
// streaming its bytes MSB first over a valid/ready byte port.
module regfile_dump_unit #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  regfile_dump_unit_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);

  localparam int BYTES_PER_REG = DATA_W / 8;
  localparam int BI_W = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_reg_idx;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [BI_W-1:0]   r_byte_idx;
  logic [DATA_W-1:0] r_shift;
  logic              w_accept;
  logic              w_last_byte;
  logic              w_last_reg;
  logic              w_abort;

  assign w_accept    = (r_state == S_SEND) && bus.out_ready;
  assign w_last_byte = (r_byte_idx == BI_W'(BYTES_PER_REG - 1));
  assign w_last_reg  = (r_reg_idx == ADDR_W'(NUM_REGS - 1));
  assign w_abort     = abort && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort outranks everything, including an accept in the same cycle.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && !abort) w_next = S_FETCH;
        S_FETCH: w_next = S_SEND;
        S_SEND:  if (w_accept && w_last_byte) w_next = w_last_reg ? S_DONE : S_FETCH;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The read port sees reg_idx only during FETCH; otherwise it holds the last index.
  always_comb begin
    bus.out_valid = (r_state == S_SEND);
    bus.out_data  = r_shift[DATA_W-1 -: 8];
    bus.rd_addr   = (r_state == S_FETCH) ? r_reg_idx : r_rd_addr;
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_DONE);
    o_dbg_state   = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_idx  <= '0;
      r_rd_addr  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
    end else if (w_abort) begin
      r_reg_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_reg_idx <= '0;
        S_FETCH: begin
          r_shift    <= bus.rd_data;
          r_byte_idx <= '0;
          r_rd_addr  <= r_reg_idx;
        end
        S_SEND: begin
          if (w_accept) begin
            if (!w_last_byte) begin
              r_shift    <= r_shift << 8;
              r_byte_idx <= r_byte_idx + BI_W'(1);
            end else if (!w_last_reg) begin
              r_reg_idx <= r_reg_idx + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: a register-file model feeds the read port, a
// queue-based scoreboard checks every accepted byte against the expected dump.
module tb_regfile_dump_unit;
  localparam int NREG = 8;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [1:0] dbg_state;

  logic [31:0] rf [NREG];
  logic [7:0]  exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int done_seen = 0;
  bit ready_mode = 0;

  regfile_dump_unit_if #(.ADDR_W(3), .DATA_W(32)) bus ();
  assign bus.rd_data = rf[bus.rd_addr];

  regfile_dump_unit #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected stream: each register in index order, big-endian bytes.
  task automatic push_dump(input logic [31:0] vals [NREG]);
    for (int r = 0; r < NREG; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(vals[r][8*b +: 8]);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_seen;
    i = 0;
    while (done_seen == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_pulse", done_seen - d0, 1);
    chk("bytes_left", exp_q.size(), 0);
  endtask

  task automatic wait_acc(input int base, input int n, input int budget);
    int i;
    i = 0;
    while ((n_acc - base) < n && i < budget) begin
      tick();
      i++;
    end
    chk("acc_reached", n_acc - base, n);
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && bus.out_valid) chk("stall_stable", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready && !abort) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("extra_byte", bus.out_data, 8'hxx);
        end else begin
          chk("stream_byte", bus.out_data, exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        chk("done_after_last", exp_q.size(), 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready && !abort;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] plan [NREG];
  int c0, base, d0;
  bit busy_ok, done_ok, valid_ok;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) rf[i] = 32'h11111111 * i;
    #2;
    chk("reset_outs", {busy, done, bus.out_valid, bus.rd_addr, bus.out_data, dbg_state},
        '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Scenario 1: pattern registers, ready held high, exact cycle timing.
    plan = rf;
    push_dump(plan);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    busy_ok = 1'b1;
    done_ok = 1'b1;
    valid_ok = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (busy !== (k <= 41)) busy_ok = 1'b0;
      if (done !== (k == 41)) done_ok = 1'b0;
      if (k == 1 && bus.out_valid !== 1'b0) valid_ok = 1'b0;
      if (k == 2 && bus.out_valid !== 1'b1) valid_ok = 1'b0;
    end
    chk("busy_window", busy_ok, 1'b1);
    chk("done_cycle41", done_ok, 1'b1);
    chk("first_valid_c2", valid_ok, 1'b1);
    chk("s1_bytes_left", exp_q.size(), 0);
    chk("s1_cyc_base", cyc - c0, 42);

    // Scenario 2: MSB-first ordering with distinctive end registers.
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    rf[0] = 32'h12345678;
    rf[7] = 32'hDEADBEEF;
    plan = rf;
    tick();
    push_dump(plan);
    pulse_start();
    wait_done(200);

    // Scenario 3: random backpressure on the pattern registers.
    for (int i = 0; i < NREG; i++) rf[i] = 32'h11111111 * i;
    plan = rf;
    ready_mode = 1;
    base = n_acc;
    tick();
    push_dump(plan);
    pulse_start();
    wait_done(2000);
    chk("s3_accepted", n_acc - base, 32);
    ready_mode = 0;
    tick();

    // Scenario 4: snapshot -- reg3 written after its fetch, reg5 before.
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    plan = rf;
    plan[5] = 32'hCAFEF00D;
    push_dump(plan);
    base = n_acc;
    pulse_start();
    wait_acc(base, 14, 200);
    rf[3] = 32'hCAFEF00D;
    rf[5] = 32'hCAFEF00D;
    wait_done(200);

    // Scenario 5: abort after 10 accepted bytes, then a full restart.
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    plan = rf;
    push_dump(plan);
    base = n_acc;
    d0 = done_seen;
    pulse_start();
    wait_acc(base, 10, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_left", exp_q.size(), 22);
    exp_q.delete();
    repeat (5) tick();
    chk("abort_no_done", done_seen - d0, 0);
    // start and abort together in IDLE stay idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 1'b0);
    tick();
    push_dump(plan);
    pulse_start();
    wait_done(200);

    // Scenario 6: asynchronous reset mid-SEND.
    for (int i = 0; i < NREG; i++) rf[i] = $urandom | 32'h01010101;
    plan = rf;
    push_dump(plan);
    base = n_acc;
    d0 = done_seen;
    pulse_start();
    wait_acc(base, 6, 200);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, bus.out_valid, bus.rd_addr, bus.out_data, dbg_state}, '0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("reset_no_done", done_seen - d0, 0);
    chk("reset_stays_idle", busy, 1'b0);

    // Scenario 7: start pulses while busy are ignored.
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    plan = rf;
    push_dump(plan);
    base = n_acc;
    d0 = done_seen;
    pulse_start();
    for (int p = 0; p < 4; p++) begin
      repeat ($urandom_range(3, 8)) tick();
      pulse_start();
    end
    wait_done(200);
    repeat (60) tick();
    chk("busy_start_bytes", n_acc - base, 32);
    chk("busy_start_dones", done_seen - d0, 1);
    chk("busy_start_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Reads every entry of the processor's 8x32 register file through one of its combinational read ports and streams the contents out as bytes over a valid/ready interface.
- Used for debug readout and end-of-test state capture, replacing simulation-only file dumps with synthesizable hardware.
- Sits beside the register block, sharing a read-port address mux with the datapath; the mux select is the busy output.

Parameters:
NUM_REGS, 8, number of register entries dumped (indices 0..NUM_REGS-1)
ADDR_W, 3, register index width; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 32, register width; must be a multiple of 8
BYTES_PER_REG, DATA_W/8 (4), bytes emitted per register (derived)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE with no done pulse
rd_addr  output  ADDR_W  register index driven to the register-file read port
rd_data  input  DATA_W  combinational read data for rd_addr, same cycle
out_data  output  8  stream byte
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts the byte when out_valid && out_ready on a clock edge
busy  output  1  high in any state except IDLE; drives the read-port mux select
done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0, reg_idx=0, byte_idx=0, shift register=0.
- IDLE:
  - start=1 -> reg_idx=0, go to FETCH.
  - start while not IDLE is ignored; no queuing.
- FETCH (one cycle):
  - rd_addr=reg_idx.
  - On the clock edge, capture rd_data into a DATA_W shift register, set byte_idx=0, go to SEND.
- SEND:
  - out_valid=1; out_data=shift_reg[DATA_W-1 -: 8], so bytes go out MSB first (big-endian per register).
  - out_data and out_valid stay stable until accepted.
  - On accept (out_valid && out_ready):
    - byte_idx < BYTES_PER_REG-1: shift left by 8, byte_idx++, remain in SEND.
    - Last byte and reg_idx < NUM_REGS-1: reg_idx++, go to FETCH; out_valid=0 during FETCH.
    - Last byte and reg_idx == NUM_REGS-1: go to DONE.
- DONE (one cycle): done=1, out_valid=0, then IDLE. busy is high in DONE and low the cycle after.
- Snapshot semantics:
  - Each register is sampled exactly once, in its FETCH cycle.
  - A datapath write to that register after its FETCH is not reflected in the stream.
  - A write in the same cycle as FETCH returns the pre-write value, because the register-file write is clocked.
- abort=1 in any non-IDLE state: next state IDLE, out_valid=0, no done pulse, counters cleared. abort has priority over an accept in the same cycle; that byte counts as not transferred.
- abort in IDLE has no effect. start and abort together in IDLE leave the block in IDLE (abort wins).
- rd_addr holds its last value when not in FETCH. It resets to 0.
- Timing with out_ready held high:
  - start at cycle 0, FETCH at cycle 1, first out_valid at cycle 2.
  - Each register takes 1+BYTES_PER_REG cycles (5 at default), 40 cycles in total.
  - done pulses at cycle 41, busy falls at cycle 42.
- Backpressure: out_ready low stalls indefinitely with no byte lost or duplicated; shift register, byte_idx and reg_idx are frozen.
- rst_n asserted mid-dump aborts immediately with reset values. After release a fresh start is required.
- rst_n deassertion must be synchronized externally; the block does not need to tolerate a start in the same cycle as reset release.

Test Plan:
- Registers preloaded 0x00000000, 0x11111111, ..., 0x77777777; start pulse with out_ready=1 -> 32 bytes 00,00,00,00,11,11,11,11,...,77; done at cycle 41; busy high for cycles 1-41.
- reg0=0x12345678, reg7=0xDEADBEEF -> byte stream begins 12,34,56,78 and ends DE,AD,BE,EF, confirming MSB-first order.
- out_ready toggled pseudo-randomly (roughly 50% duty) -> exactly 32 accepted bytes, identical sequence to the first scenario; out_data never changes while out_valid=1 && out_ready=0.
- reg3 written to 0xCAFEF00D after its FETCH cycle (during its SEND) -> stream still shows the old reg3 value. reg5 written to 0xCAFEF00D before its FETCH -> stream shows CA,FE,F0,0D.
- abort asserted after 10 accepted bytes -> out_valid=0 next cycle, no done, busy=0. A new start then restarts from reg0 and produces the full 32 bytes.
- rst_n pulsed low mid-SEND -> all outputs at reset values asynchronously. start pulses while busy are ignored, with no second dump and no extra bytes.
